ram_port_arbiter: RTL and testbench

Shares the single synchronous data-RAM port between three requesters: the CPU RAM unit (RAM/URAM/SAVE operations), the stack unit (PUSH/POP), and an external DMA/IO master. Each requester uses a req/ack handshake. The arbiter grants round-robin, sequences one RAM access at a time, and returns read data with a one-cycle acknowledge. It sits between the execution units and the RAM macro, so those units no longer drive the RAM directly.

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/ram_port_arbiter_rr_picker.sv | 37 +++
 rtl/ram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the data-RAM port arbiter.
//   arb_state_e   : arbiter FSM state encoding (IDLE/ISSUE/WAIT/ACK)
//   NREQ          : number of requesters sharing the RAM port
//   REQ_CPU/STK/DMA : requester indices (bit positions in req/we/ack)
//   rr_next()     : round-robin successor of a requester index
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  localparam int NREQ = 3;

  localparam logic [1:0] REQ_CPU = 2'd0;
  localparam logic [1:0] REQ_STK = 2'd1;
  localparam logic [1:0] REQ_DMA = 2'd2;

  // Successor index modulo NREQ; index 3 is never produced.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= REQ_DMA) ? REQ_CPU : idx + 2'd1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req_i[2:0]        : per-requester request bits
//   last_grant_i[1:0] : index of the most recently completed requester
//   winner_o[1:0]     : first requesting index after last_grant (wrapping)
//   any_req_o         : at least one request is pending
module rr_picker
  import ram_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] winner_o,
  output logic       any_req_o
);

  logic [3:0] req_ext;
  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  always_comb begin
    // Padding to 4 bits lets a 2-bit index address the vector safely.
    req_ext   = {1'b0, req_i};
    cand0     = rr_next(last_grant_i);
    cand1     = rr_next(cand0);
    cand2     = rr_next(cand1);
    any_req_o = |req_i;
    winner_o  = last_grant_i;
    if (req_ext[cand0]) begin
      winner_o = cand0;
    end else if (req_ext[cand1]) begin
      winner_o = cand1;
    end else if (req_ext[cand2]) begin
      winner_o = cand2;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single synchronous data-RAM port between the
// CPU RAM unit (0), the stack unit (1) and the DMA/IO master (2).
//   clk, rst            : clock, asynchronous active-high reset
//   req_i[2:0], we_i    : per-requester request level / write enable
//   addrN_i, wdataN_i   : per-requester address and write data
//   ack_o[2:0]          : one-hot single-cycle completion pulse
//   rdata_o             : read data, valid from the ack cycle until next read
//   busy_o              : arbiter not idle
//   ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i : RAM macro port
//   dbg_state_o         : current FSM state
//
// Handshake: a requester raises req and holds addr/we/wdata stable until it
// sees its ack bit; it must drop req in the cycle after ack, since a req still
// high when the arbiter is back in IDLE is a new request. Everything is
// latched at grant, so later changes (including dropping req) are ignored and
// the access always completes with an ack.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_i,
  input  logic [2:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] wdata2_i,
  output logic [2:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output arb_state_e        dbg_state_o
);

  localparam int         CNT_W  = 2;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LAT - 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        winner_q;
  logic [1:0]        last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        pick;
  logic              any_req;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rr_picker u_rr_picker (
    .req_i        (req_i),
    .last_grant_i (last_grant_q),
    .winner_o     (pick),
    .any_req_o    (any_req)
  );

  assign grant = (state_q == ST_IDLE) && any_req;

  // Request mux feeding the grant-time latches.
  always_comb begin
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    sel_we    = we_i[0];
    case (pick)
      REQ_STK: begin
        sel_addr  = addr1_i;
        sel_wdata = wdata1_i;
        sel_we    = we_i[1];
      end
      REQ_DMA: begin
        sel_addr  = addr2_i;
        sel_wdata = wdata2_i;
        sel_we    = we_i[2];
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ram_we_q ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs (Moore)
  always_comb begin
    ack_o       = (state_q == ST_ACK) ? (3'b001 << winner_q) : 3'b000;
    busy_o      = (state_q != ST_IDLE);
    dbg_state_o = state_q;
  end

  // Grant latches, latency counter, read capture and round-robin pointer.
  // ram_en is registered so it is high exactly during the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner_q     <= REQ_CPU;
      last_grant_q <= REQ_DMA;
      cnt_q        <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      ram_en_q <= grant;
      if (grant) begin
        winner_q    <= pick;
        ram_addr_q  <= sel_addr;
        ram_wdata_q <= sel_wdata;
        ram_we_q    <= sel_we;
      end
      if ((state_q == ST_ISSUE) && !ram_we_q) begin
        cnt_q <= LAT_M1;
      end
      if (state_q == ST_WAIT) begin
        if (cnt_q == '0) begin
          rdata_q <= ram_rdata_i;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
      if (state_q == ST_ACK) begin
        last_grant_q <= winner_q;
      end
    end
  end

  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with two instances
// (READ_LAT=1 as dut_a, READ_LAT=3 as dut_b) sharing requester inputs, each
// attached to its own small RAM model.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int AW = 15;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared requester inputs ----------------
  logic [2:0]    req = 3'b000;
  logic [2:0]    we  = 3'b000;
  logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;

  // ---------------- dut_a (READ_LAT=1) ----------------
  logic [2:0]    ack_a;
  logic [DW-1:0] rdata_a, ram_wdata_a, ram_rdata_a;
  logic          busy_a, ram_en_a, ram_we_a;
  logic [AW-1:0] ram_addr_a;
  arb_state_e    st_a;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .addr2_i(addr2),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .wdata2_i(wdata2),
    .ack_o(ack_a), .rdata_o(rdata_a), .busy_o(busy_a),
    .ram_en_o(ram_en_a), .ram_we_o(ram_we_a), .ram_addr_o(ram_addr_a),
    .ram_wdata_o(ram_wdata_a), .ram_rdata_i(ram_rdata_a), .dbg_state_o(st_a)
  );

  // ---------------- dut_b (READ_LAT=3) ----------------
  logic [2:0]    ack_b;
  logic [DW-1:0] rdata_b, ram_wdata_b, ram_rdata_b;
  logic          busy_b, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_b;
  arb_state_e    st_b;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .addr2_i(addr2),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .wdata2_i(wdata2),
    .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b),
    .ram_en_o(ram_en_b), .ram_we_o(ram_we_b), .ram_addr_o(ram_addr_b),
    .ram_wdata_o(ram_wdata_b), .ram_rdata_i(ram_rdata_b), .dbg_state_o(st_b)
  );

  // ---------------- RAM models ----------------
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];
  logic [DW-1:0] pa0;
  logic [DW-1:0] pb0, pb1, pb2;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    pa0 = '0; pb0 = '0; pb1 = '0; pb2 = '0;
  end

  always @(posedge clk) begin
    if (ram_en_a) begin
      if (ram_we_a) mem_a[ram_addr_a[7:0]] <= ram_wdata_a;
      else          pa0 <= mem_a[ram_addr_a[7:0]];
    end
    if (ram_en_b) begin
      if (ram_we_b) mem_b[ram_addr_b[7:0]] <= ram_wdata_b;
      else          pb0 <= mem_b[ram_addr_b[7:0]];
    end
    pb1 <= pb0;
    pb2 <= pb1;
  end

  assign ram_rdata_a = pa0;
  assign ram_rdata_b = pb2;

  // ---------------- per-cycle history ----------------
  logic [2:0]    ack_a_h [0:31];
  logic [2:0]    ack_b_h [0:31];
  logic [DW-1:0] rd_a_h  [0:31];
  logic [DW-1:0] rd_b_h  [0:31];
  logic          en_a_h  [0:31];
  logic          we_a_h  [0:31];
  logic          busy_a_h[0:31];
  logic [AW-1:0] addr_a_h[0:31];
  int            en_a_cnt, en_b_cnt;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; samples mid-cycle at the falling edge, returns at
  // the next posedge+1.
  task automatic sample_cycle(input int c);
    @(negedge clk);
    ack_a_h[c]  = ack_a;
    ack_b_h[c]  = ack_b;
    rd_a_h[c]   = rdata_a;
    rd_b_h[c]   = rdata_b;
    en_a_h[c]   = ram_en_a;
    we_a_h[c]   = ram_we_a;
    busy_a_h[c] = busy_a;
    addr_a_h[c] = ram_addr_a;
    if (ram_en_a) en_a_cnt++;
    if (ram_en_b) en_b_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 3'b000;
    we  = 3'b000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en_a_cnt = 0;
    en_b_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  int drop_c [3];
  int n_acks;
  logic [2:0] ack_seq [0:3];
  int ack_cyc [0:3];
  int first_cyc;
  logic [2:0] first_ack;

  initial begin
    en_a_cnt = 0;
    en_b_cnt = 0;
    do_reset();

    // Reset values
    @(negedge clk);
    check("rst_ack",   {29'd0, ack_a}, 32'h0);
    check("rst_rdata", {16'd0, rdata_a}, 32'h0);
    check("rst_busy",  {31'd0, busy_a}, 32'h0);
    check("rst_en",    {31'd0, ram_en_a}, 32'h0);
    check("rst_we",    {31'd0, ram_we_a}, 32'h0);
    check("rst_addr",  {17'd0, ram_addr_a}, 32'h0);
    check("rst_wdata", {16'd0, ram_wdata_a}, 32'h0);
    check("rst_state", {30'd0, st_a}, {30'd0, ST_IDLE});
    @(posedge clk);
    #1;

    // Single write by CPU: ram_en in cycle 1, ack in cycle 2
    req = 3'b001; we = 3'b001; addr0 = 15'h0010; wdata0 = 16'hBEEF;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) req = 3'b000;
      sample_cycle(c);
    end
    check("wr_en_c1",    {31'd0, en_a_h[1]}, 32'h1);
    check("wr_we_c1",    {31'd0, we_a_h[1]}, 32'h1);
    check("wr_addr_c1",  {17'd0, addr_a_h[1]}, 32'h0010);
    check("wr_busy_c0",  {31'd0, busy_a_h[0]}, 32'h0);
    check("wr_busy_c1",  {31'd0, busy_a_h[1]}, 32'h1);
    check("wr_ack_c1",   {29'd0, ack_a_h[1]}, 32'h0);
    check("wr_ack_a_c2", {29'd0, ack_a_h[2]}, 32'h1);
    check("wr_ack_b_c2", {29'd0, ack_b_h[2]}, 32'h1);
    check("wr_busy_c3",  {31'd0, busy_a_h[3]}, 32'h0);
    check("wr_en_cnt_a", en_a_cnt, 1);
    check("wr_en_cnt_b", en_b_cnt, 1);

    // Single read by stack: ack at 2+READ_LAT
    do_reset();
    req = 3'b010; we = 3'b000; addr1 = 15'h0010;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) req = 3'b000;
      sample_cycle(c);
    end
    check("rd_ack_a_c2",  {29'd0, ack_a_h[2]}, 32'h0);
    check("rd_rdata_a_c2",{16'd0, rd_a_h[2]}, 32'h0);
    check("rd_ack_a_c3",  {29'd0, ack_a_h[3]}, 32'h2);
    check("rd_rdata_a_c3",{16'd0, rd_a_h[3]}, 32'hBEEF);
    check("rd_ack_b_c4",  {29'd0, ack_b_h[4]}, 32'h0);
    check("rd_ack_b_c5",  {29'd0, ack_b_h[5]}, 32'h2);
    check("rd_rdata_b_c5",{16'd0, rd_b_h[5]}, 32'hBEEF);
    check("rd_en_cnt_a",  en_a_cnt, 1);
    check("rd_en_cnt_b",  en_b_cnt, 1);

    // Write by stack leaves rdata untouched; ram_addr holds in IDLE
    en_a_cnt = 0; en_b_cnt = 0;
    req = 3'b010; we = 3'b010; addr1 = 15'h0020; wdata1 = 16'h1234;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) req = 3'b000;
      sample_cycle(c);
    end
    check("wr2_ack_a_c2",  {29'd0, ack_a_h[2]}, 32'h2);
    check("wr2_rdata_a",   {16'd0, rd_a_h[3]}, 32'hBEEF);
    check("wr2_rdata_b",   {16'd0, rd_b_h[3]}, 32'hBEEF);
    check("wr2_addr_hold", {17'd0, addr_a_h[5]}, 32'h0020);
    check("wr2_en_idle",   {31'd0, en_a_h[5]}, 32'h0);

    // DMA read with req dropped in cycle 2: access completes once
    do_reset();
    req = 3'b100; we = 3'b000; addr2 = 15'h0020;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) req = 3'b000;
      sample_cycle(c);
    end
    check("drop_ack_a_c3",   {29'd0, ack_a_h[3]}, 32'h4);
    check("drop_rdata_a_c3", {16'd0, rd_a_h[3]}, 32'h1234);
    check("drop_ack_b_c5",   {29'd0, ack_b_h[5]}, 32'h4);
    check("drop_rdata_b_c5", {16'd0, rd_b_h[5]}, 32'h1234);
    check("drop_en_cnt_a",   en_a_cnt, 1);
    check("drop_en_cnt_b",   en_b_cnt, 1);

    // Contention: all three writes held from reset, round-robin order
    rst = 1'b1;
    req = 3'b111; we = 3'b111;
    addr0 = 15'h0030; addr1 = 15'h0031; addr2 = 15'h0032;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drop_c[i] = -10;
    n_acks = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (drop_c[i] == c) req[i] = 1'b0;
        if (drop_c[i] + 1 == c) req[i] = 1'b1;
      end
      sample_cycle(c);
      if (ack_a_h[c] != 3'b000) begin
        if (n_acks < 4) begin
          ack_seq[n_acks] = ack_a_h[c];
          ack_cyc[n_acks] = c;
        end
        n_acks++;
        for (int i = 0; i < 3; i++) if (ack_a_h[c][i]) drop_c[i] = c + 1;
      end
    end
    check("rr_n_acks", n_acks, 4);
    if (n_acks >= 4) begin
      check("rr_ack0", {29'd0, ack_seq[0]}, 32'h1);
      check("rr_ack1", {29'd0, ack_seq[1]}, 32'h2);
      check("rr_ack2", {29'd0, ack_seq[2]}, 32'h4);
      check("rr_ack3", {29'd0, ack_seq[3]}, 32'h1);
      check("rr_cyc0", ack_cyc[0], 2);
      check("rr_cyc3", ack_cyc[3], 11);
    end

    // Reset during WAIT on dut_b, then grant order restarts at requester 0
    do_reset();
    req = 3'b010; we = 3'b000; addr1 = 15'h0010;
    sample_cycle(0);
    req = 3'b000;
    sample_cycle(1);
    sample_cycle(2);
    check("rw_state_c2", {30'd0, st_b}, {30'd0, ST_WAIT});
    rst = 1'b1;
    @(negedge clk);
    check("rw_ack",   {29'd0, ack_b}, 32'h0);
    check("rw_rdata", {16'd0, rdata_b}, 32'h0);
    check("rw_busy",  {31'd0, busy_b}, 32'h0);
    check("rw_en",    {31'd0, ram_en_b}, 32'h0);
    check("rw_addr",  {17'd0, ram_addr_b}, 32'h0);
    @(posedge clk);
    #1;
    req = 3'b111; we = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    first_cyc = -1;
    first_ack = 3'b000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (first_cyc < 0 && ack_b != 3'b000) begin
        first_cyc = c;
        first_ack = ack_b;
      end
      @(posedge clk);
      #1;
    end
    req = 3'b000;
    check("rw_first_seen", (first_cyc >= 0) ? 32'h1 : 32'h0, 32'h1);
    check("rw_first_ack",  {29'd0, first_ack}, 32'h1);
    check("rw_first_cyc",  first_cyc, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
